trellis_bidir_seq: RTL and testbench

//   Half-duplex transaction sequencer for one ECP5 bidirectional pad (TRELLIS_IO, DIR="BIDIR").

---
 rtl/trellis_bidir_seq.sv | 124 ++++++++++++
 tb/tb_trellis_bidir_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trellis_bidir_seq.sv
// Half-duplex sequencer for one bidirectional pad: shifts a command word out MSB-first,
// optionally releases the pad for a turnaround, then shifts a response word in.
module trellis_bidir_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int TURN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_t,
  input  logic             pad_o
);

  localparam int PH_W    = $clog2(DIV);
  localparam int CNT_MAX = (TURN > WIDTH) ? TURN : WIDTH;
  localparam int BIT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DIV - 1);
  localparam logic [BIT_W-1:0] WR_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] TN_LAST = BIT_W'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_READ,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic             rd_q;
  logic             pad_o_q;
  logic             period_end;
  logic             accept;

  assign period_end = (phase_q == PH_LAST);
  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_WRITE;
      S_WRITE: begin
        if (period_end && bit_q == WR_LAST) begin
          if (!rd_q)         state_d = S_IDLE;
          else if (TURN > 0) state_d = S_TURN;
          else               state_d = S_READ;
        end
      end
      S_TURN:  if (period_end && bit_q == TN_LAST) state_d = S_READ;
      S_READ:  if (period_end && bit_q == WR_LAST) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Both counters restart on every state change, so each state counts from zero.
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    if (state_d != state_q) begin
      phase_d = '0;
      bit_d   = '0;
    end else if (state_q inside {S_WRITE, S_TURN, S_READ}) begin
      if (period_end) begin
        phase_d = '0;
        bit_d   = bit_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      pad_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      pad_o_q <= pad_o;
      if (state_q == S_READ && period_end)
        rx_q <= (rx_q << 1) | WIDTH'(pad_o_q);
    end
  end

  // NOTE: the transmit word and read flag carry no reset; they are loaded on every accept
  // and only observed afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_q <= cmd_data;
      rd_q <= cmd_rd;
    end else if (state_q == S_WRITE && period_end) begin
      tx_q <= tx_q << 1;
    end
  end

  assign pad_t     = (state_q != S_WRITE);
  assign pad_i     = (state_q == S_WRITE) ? tx_q[WIDTH-1] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rx_q;

endmodule

// File: tb/tb_trellis_bidir_seq.sv
// Directed bench for trellis_bidir_seq: a cycle-count transaction model checks every cycle,
// and hand-computed literals pin the key cycles of each scenario.
module tb_trellis_bidir_seq;

  localparam int W = 8;
  localparam int D = 4;
  localparam int T = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_rd = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic         pad_i;
  logic         pad_t;
  logic         pad_o = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  trellis_bidir_seq #(.WIDTH(W), .DIV(D), .TURN(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_rd    (cmd_rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .pad_i     (pad_i),
    .pad_t     (pad_t),
    .pad_o     (pad_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: cycle t counts from 1 on the cycle after accept.
  bit           m_active = 1'b0;
  bit           m_rd = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_rsp = '0;

  always @(negedge clk) begin : cmp
    logic e_t, e_i, e_rv, e_cr;
    int   rel;
    if (started) begin
      e_t  = 1'b1;
      e_i  = 1'b0;
      e_rv = 1'b0;
      e_cr = !m_active && !rst;
      if (m_active) begin
        if (m_t <= W * D) begin
          e_t = 1'b0;
          e_i = m_data[W - 1 - (m_t - 1) / D];
        end else if (m_t > (2 * W + T) * D) begin
          e_rv = 1'b1;
        end else if (m_t > (W + T) * D) begin
          rel = m_t - (W + T) * D;
          if (rel % D == D - 1) m_rsp = {m_rsp[W-2:0], pad_o};
        end
      end
      check("pad_t", pad_t, e_t);
      check("pad_i", pad_i, e_i);
      check("busy", busy, m_active);
      check("cmd_ready", cmd_ready, e_cr);
      check("rsp_valid", rsp_valid, e_rv);
      if (e_rv) check("rsp_data", rsp_data, m_rsp);

      if (rst) begin
        m_active = 1'b0;
        m_rsp    = '0;
      end else if (!m_active) begin
        if (cmd_valid) begin
          m_active = 1'b1;
          m_t      = 1;
          m_data   = cmd_data;
          m_rd     = cmd_rd;
        end
      end else if (!m_rd && m_t == W * D) begin
        m_active = 1'b0;
      end else if (m_rd && m_t > (2 * W + T) * D && rsp_ready) begin
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic rd);
    int n;
    n = 0;
    cmd_data  = d;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("accept_timeout", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Pad drives the response word during cycles 41..72; elsewhere a toggling filler.
  function automatic logic pad_bit(input int c, input logic [W-1:0] w);
    logic [31:0] cv;
    cv = c;
    if (c >= 41 && c <= 72) return w[W - 1 - (c - 41) / D];
    return cv[0];
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int a5_bits[8];
    a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};

    // Reset held three cycles with a command offered.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h11;
    repeat (3) begin
      step();
      started = 1'b1;
      check("rst_pad_t", pad_t, 1'b1);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    check("post_rst_rsp_data", rsp_data, 8'h00);
    step();

    // Write-only 0xA5.
    send(8'hA5, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      check("wr_pad_t", pad_t, 1'b0);
      check("wr_pad_i", pad_i, a5_bits[(c - 1) / 4]);
      step();
    end
    check("wr_end_pad_t", pad_t, 1'b1);
    check("wr_end_cmd_ready", cmd_ready, 1'b1);
    step();

    // Read 0x3C with 0x96 returned and ten cycles of backpressure.
    send(8'h3C, 1'b1);
    for (int c = 1; c <= 72; c++) begin
      pad_o = pad_bit(c, 8'h96);
      if (c >= 33) check("rd_pad_t", pad_t, 1'b1);
      step();
    end
    pad_o = 1'b0;
    for (int c = 73; c < 83; c++) begin
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, 8'h96);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    check("hs_rsp_valid", rsp_valid, 1'b1);
    step();
    rsp_ready = 1'b0;
    check("hs_busy", busy, 1'b0);
    check("hs_cmd_ready", cmd_ready, 1'b1);
    check("hs_rsp_valid_low", rsp_valid, 1'b0);
    step();

    // Reset in the middle of READ, then a clean write-only 0xFF.
    send(8'h3C, 1'b1);
    for (int c = 1; c < 50; c++) begin
      pad_o = pad_bit(c, 8'h96);
      step();
    end
    rst = 1'b1;
    step();
    rst   = 1'b0;
    pad_o = 1'b0;
    check("mid_rst_pad_t", pad_t, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_data", rsp_data, 8'h00);
    step();
    send(8'hFF, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      check("ff_pad_i", pad_i, 1'b1);
      step();
    end
    check("ff_end_pad_t", pad_t, 1'b1);
    check("ff_end_busy", busy, 1'b0);
    step();

    // Back-to-back: 0x5A then 0xC3 held on the command port.
    send(8'h5A, 1'b0);
    cmd_valid = 1'b1;
    cmd_data  = 8'hC3;
    cmd_rd    = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check("b2b_pad_t", pad_t, 1'b0);
      step();
    end
    check("b2b_c33_cmd_ready", cmd_ready, 1'b1);
    check("b2b_c33_pad_t", pad_t, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("b2b_c34_pad_t", pad_t, 1'b0);
    check("b2b_c34_pad_i", pad_i, 1'b1);
    check("b2b_c34_busy", busy, 1'b1);
    for (int c = 2; c <= 32; c++) step();
    step();
    check("b2b_end_pad_t", pad_t, 1'b1);
    check("b2b_end_cmd_ready", cmd_ready, 1'b1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
